// File: rtl/mult_ctrl_if.sv
// Request / result / multiplier-port bundle for mult_ctrl.
// The slave modport is the controller's view; master is the requester plus the external multiplier.
interface mult_ctrl_if #(
   parameter int XLEN = 64
);
   logic                 i_valid;
   logic                 o_ready;
   logic [2:0]           i_op;
   logic [XLEN-1:0]      i_src1;
   logic [XLEN-1:0]      i_src2;
   logic                 i_flush;
   logic [XLEN+1:0]      o_mult_x;
   logic [XLEN+1:0]      o_mult_y;
   logic [2*XLEN+3:0]    i_mult_res;
   logic                 o_out_valid;
   logic                 i_out_ready;
   logic [XLEN-1:0]      o_res;
   logic                 o_busy;

   modport slave (
      input  i_valid, i_op, i_src1, i_src2, i_flush, i_mult_res, i_out_ready,
      output o_ready, o_mult_x, o_mult_y, o_out_valid, o_res, o_busy
   );

   modport master (
      output i_valid, i_op, i_src1, i_src2, i_flush, i_mult_res, i_out_ready,
      input  o_ready, o_mult_x, o_mult_y, o_out_valid, o_res, o_busy
   );
endinterface

// File: rtl/mult_ctrl.sv
// Sequencing controller wrapped around an external (XLEN+2)-bit signed multiplier.
// MUL_LAT (1..7) is the number of cycles the product is given to settle before capture.
//
// state | meaning
// IDLE  | ready for a request (unless flushing)
// CALC  | operands registered, waiting for the product to settle
// DONE  | result held until consumed or flushed
module mult_ctrl #(
   parameter int XLEN    = 64,
   parameter int MUL_LAT = 2
) (
   input logic         i_clk,
   input logic         i_rst_n,
   mult_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_MULW   = 3'd4;
   localparam logic [2:0] CNT_LOAD  = 3'(MUL_LAT - 1);

   state_t            state;
   state_t            state_nxt;
   logic [2:0]        cnt;
   logic [2:0]        op_q;
   logic              accept;
   logic              capture;
   logic              x_signed;
   logic              y_signed;
   logic [XLEN-1:0]   src1_sel;
   logic [XLEN-1:0]   src2_sel;
   logic [XLEN+1:0]   ext_x;
   logic [XLEN+1:0]   ext_y;
   logic [XLEN-1:0]   res_sel;
   logic              unused_res_hi;

   assign bus.o_ready     = (state == IDLE) && !bus.i_flush;
   assign bus.o_busy      = (state != IDLE);
   assign bus.o_out_valid = (state == DONE);
   assign accept          = bus.i_valid && bus.o_ready;
   assign unused_res_hi   = ^bus.i_mult_res[2*XLEN+3:2*XLEN];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Flush outranks both completion and the result handshake.
   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            if (accept) state_nxt = CALC;
         end
         CALC: begin
            if (bus.i_flush) begin
               state_nxt = IDLE;
            end else if (cnt == 3'd0) begin
               state_nxt = DONE;
               capture   = 1'b1;
            end
         end
         DONE: begin
            if (bus.i_flush || bus.i_out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      x_signed = 1'b1;
      y_signed = 1'b1;
      src1_sel = bus.i_src1;
      src2_sel = bus.i_src2;
      case (bus.i_op)
         OP_MULHSU: y_signed = 1'b0;
         OP_MULHU: begin
            x_signed = 1'b0;
            y_signed = 1'b0;
         end
         OP_MULW: begin
            src1_sel = {{(XLEN-32){bus.i_src1[31]}}, bus.i_src1[31:0]};
            src2_sel = {{(XLEN-32){bus.i_src2[31]}}, bus.i_src2[31:0]};
         end
         default: ;
      endcase
      ext_x = {{2{x_signed & src1_sel[XLEN-1]}}, src1_sel};
      ext_y = {{2{y_signed & src2_sel[XLEN-1]}}, src2_sel};
   end

   // Reserved encodings fall through to the MUL selection.
   always_comb begin
      res_sel = bus.i_mult_res[XLEN-1:0];
      case (op_q)
         OP_MULH, OP_MULHSU, OP_MULHU: res_sel = bus.i_mult_res[2*XLEN-1:XLEN];
         OP_MULW: res_sel = {{(XLEN-32){bus.i_mult_res[31]}}, bus.i_mult_res[31:0]};
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         bus.o_mult_x <= '0;
         bus.o_mult_y <= '0;
         bus.o_res    <= '0;
         op_q         <= OP_MUL;
         cnt          <= 3'd0;
      end else begin
         if (accept) begin
            bus.o_mult_x <= ext_x;
            bus.o_mult_y <= ext_y;
            op_q         <= bus.i_op;
            cnt          <= CNT_LOAD;
         end else if ((state == CALC) && (cnt != 3'd0)) begin
            cnt <= cnt - 3'd1;
         end
         if (capture) bus.o_res <= res_sel;
      end
   end

endmodule

// File: tb/tb_mult_ctrl.sv
// Scoreboard bench for mult_ctrl: the driver queues expected results on accept, a monitor checks them on handshake.
// The multiplier model returns a corrupted product until the operands have been stable long enough.
module tb_mult_ctrl;
   localparam int XLEN    = 64;
   localparam int MUL_LAT = 2;
   localparam int PW      = 2*XLEN + 4;

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_MULW   = 3'd4;

   typedef struct {
      logic [63:0] res;
      int          acc;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_tests;
   int   n_fail;
   int   age;
   logic prev_ov;
   logic [XLEN+1:0] px;
   logic [XLEN+1:0] py;
   logic signed [PW-1:0] prod;
   exp_t q[$];

   mult_ctrl_if #(.XLEN(XLEN)) bus ();

   mult_ctrl #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   assign prod = PW'($signed(bus.o_mult_x)) * PW'($signed(bus.o_mult_y));
   assign bus.i_mult_res = (age >= MUL_LAT - 1) ? prod : ~prod;

   always @(posedge clk) begin
      #1;
      if (bus.o_mult_x !== px || bus.o_mult_y !== py) age = 0;
      else if (age < 100) age = age + 1;
      px = bus.o_mult_x;
      py = bus.o_mult_y;
   end

   task automatic check(input string name, input logic [131:0] act, input logic [131:0] want);
      n_tests++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, want);
      end
   endtask

   task automatic fail(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: bound expired", name);
   endtask

   // Monitor: latency on the first DONE cycle, result value on each handshake.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.o_out_valid && !prev_ov && q.size() != 0)
            check("latency", 132'(cyc - q[0].acc), 132'(MUL_LAT + 1));
         if (bus.o_out_valid && bus.i_out_ready && !bus.i_flush) begin
            if (q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_result: got %h expected none", bus.o_res);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("result", 132'(bus.o_res), 132'(e.res));
            end
         end
      end
      prev_ov = rst_n && bus.o_out_valid;
   end

   task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] want, input bit push, output int acc);
      acc = -1;
      @(posedge clk); #1;
      bus.i_valid = 1'b1;
      bus.i_op    = op;
      bus.i_src1  = a;
      bus.i_src2  = b;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.o_ready) begin
            acc = cyc;
            if (push) q.push_back('{want, cyc});
            @(posedge clk); #1;
            bus.i_valid = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
      bus.i_valid = 1'b0;
      fail("accept_timeout");
   endtask

   task automatic wait_valid();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.o_out_valid) return;
      end
      fail("valid_timeout");
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (!bus.o_busy) return;
      end
      fail("idle_timeout");
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int a1;
      int a2;
      bit saw_ov;
      n_tests = 0;
      n_fail  = 0;
      cyc     = 0;
      age     = 0;
      prev_ov = 1'b0;
      px      = '0;
      py      = '0;
      rst_n   = 1'b1;
      bus.i_valid     = 1'b0;
      bus.i_op        = 3'd0;
      bus.i_src1      = '0;
      bus.i_src2      = '0;
      bus.i_flush     = 1'b0;
      bus.i_out_ready = 1'b1;

      #3 rst_n = 1'b0;
      #1;
      check("rst_ready",  132'(bus.o_ready), 132'(1));
      check("rst_busy",   132'(bus.o_busy), 132'(0));
      check("rst_ovalid", 132'(bus.o_out_valid), 132'(0));
      check("rst_res",    132'(bus.o_res), 132'(0));
      check("rst_x",      132'(bus.o_mult_x), 132'(0));
      check("rst_y",      132'(bus.o_mult_y), 132'(0));
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      // Basic ops, each followed by a return to idle.
      issue(OP_MUL, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFA, 1, a1);
      check("mul_x", 132'(bus.o_mult_x), 132'(66'h0_0000_0000_0000_0003));
      check("mul_y", 132'(bus.o_mult_y), 132'(66'h3_FFFF_FFFF_FFFF_FFFE));
      wait_idle();
      issue(OP_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1, a1);
      check("mulhu_x", 132'(bus.o_mult_x), 132'(66'h0_FFFF_FFFF_FFFF_FFFF));
      wait_idle();
      issue(OP_MULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1, a1);
      wait_idle();
      issue(OP_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1, a1);
      check("mulhsu_x", 132'(bus.o_mult_x), 132'(66'h3_FFFF_FFFF_FFFF_FFFF));
      check("mulhsu_y", 132'(bus.o_mult_y), 132'(66'h0_FFFF_FFFF_FFFF_FFFF));
      wait_idle();
      issue(OP_MULW, 64'h1234_5678_7FFF_FFFF, 64'h2, 64'hFFFF_FFFF_FFFF_FFFE, 1, a1);
      check("mulw_x", 132'(bus.o_mult_x), 132'(66'h0_0000_0000_7FFF_FFFF));
      wait_idle();
      issue(3'd7, 64'h1_0000_0000, 64'h1_0000_0003, 64'h0000_0003_0000_0000, 1, a1);
      wait_idle();
      issue(OP_MULH, 64'h8000_0000_0000_0000, 64'h2, 64'hFFFF_FFFF_FFFF_FFFF, 1, a1);
      wait_idle();

      // Back-to-back: minimum initiation interval.
      issue(OP_MUL, 64'd7, 64'd9, 64'd63, 1, a1);
      issue(OP_MUL, 64'd11, 64'd13, 64'd143, 1, a2);
      check("init_interval", 132'(a2 - a1), 132'(MUL_LAT + 2));
      wait_idle();

      // Back-pressure in DONE with a competing request.
      bus.i_out_ready = 1'b0;
      issue(OP_MULHU, 64'h8000_0000_0000_0000, 64'h2, 64'h1, 1, a1);
      wait_valid();
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         bus.i_valid = 1'b1;
         bus.i_op    = OP_MUL;
         bus.i_src1  = 64'hAAAA;
         bus.i_src2  = 64'h5555;
         @(negedge clk);
         check("bp_ovalid", 132'(bus.o_out_valid), 132'(1));
         check("bp_res",    132'(bus.o_res), 132'(64'h1));
         check("bp_ready",  132'(bus.o_ready), 132'(0));
         check("bp_x",      132'(bus.o_mult_x), 132'(66'h0_8000_0000_0000_0000));
      end
      @(posedge clk); #1;
      bus.i_valid     = 1'b0;
      bus.i_out_ready = 1'b1;
      wait_idle();
      repeat (2) @(negedge clk);
      check("bp_no_accept_busy", 132'(bus.o_busy), 132'(0));
      check("bp_no_accept_x", 132'(bus.o_mult_x), 132'(66'h0_8000_0000_0000_0000));

      // Flush during CALC.
      issue(OP_MUL, 64'd5, 64'd5, 64'd25, 0, a1);
      bus.i_flush = 1'b1;
      @(negedge clk);
      check("flush_gates_ready", 132'(bus.o_ready), 132'(0));
      @(posedge clk); #1;
      bus.i_flush = 1'b0;
      @(negedge clk);
      check("fcalc_busy",   132'(bus.o_busy), 132'(0));
      check("fcalc_ovalid", 132'(bus.o_out_valid), 132'(0));
      saw_ov = 1'b0;
      repeat (MUL_LAT + 3) begin
         @(negedge clk);
         if (bus.o_out_valid) saw_ov = 1'b1;
      end
      check("fcalc_no_valid", 132'(saw_ov), 132'(0));
      issue(OP_MUL, 64'd6, 64'd7, 64'd42, 1, a1);
      wait_idle();

      // Flush coincident with out_ready in DONE.
      issue(OP_MUL, 64'd9, 64'd9, 64'd81, 0, a1);
      repeat (MUL_LAT - 1) @(posedge clk);
      @(posedge clk); #1;
      bus.i_flush = 1'b1;
      @(negedge clk);
      check("fdone_in_done", 132'(bus.o_out_valid), 132'(1));
      @(posedge clk); #1;
      bus.i_flush = 1'b0;
      @(negedge clk);
      check("fdone_ovalid", 132'(bus.o_out_valid), 132'(0));
      check("fdone_busy",   132'(bus.o_busy), 132'(0));

      // Request presented together with flush is not taken.
      @(posedge clk); #1;
      bus.i_valid = 1'b1;
      bus.i_flush = 1'b1;
      bus.i_op    = OP_MUL;
      bus.i_src1  = 64'd2;
      bus.i_src2  = 64'd2;
      @(negedge clk);
      check("flush_req_ready", 132'(bus.o_ready), 132'(0));
      @(posedge clk); #1;
      bus.i_valid = 1'b0;
      bus.i_flush = 1'b0;
      @(negedge clk);
      check("flush_req_busy", 132'(bus.o_busy), 132'(0));
      issue(OP_MULW, 64'h0000_0000_FFFF_FFFF, 64'h3, 64'hFFFF_FFFF_FFFF_FFFD, 1, a1);
      wait_idle();

      // Asynchronous reset mid-CALC.
      issue(OP_MUL, 64'd100, 64'd3, 64'd300, 0, a1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy",   132'(bus.o_busy), 132'(0));
      check("arst_ovalid", 132'(bus.o_out_valid), 132'(0));
      check("arst_res",    132'(bus.o_res), 132'(0));
      check("arst_x",      132'(bus.o_mult_x), 132'(0));
      check("arst_y",      132'(bus.o_mult_y), 132'(0));
      @(negedge clk) rst_n = 1'b1;
      #1;
      check("arst_ready_rel", 132'(bus.o_ready), 132'(1));
      @(negedge clk);
      check("arst_ready_cyc", 132'(bus.o_ready), 132'(1));
      check("arst_busy_cyc",  132'(bus.o_busy), 132'(0));
      issue(OP_MULHU, 64'h8000_0000_0000_0000, 64'h4, 64'h2, 1, a1);
      wait_idle();

      repeat (3) @(negedge clk);
      check("sb_drain", 132'(q.size()), 132'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
